// File: rtl/dp_wait_memory.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module   : dp_wait_memory                                                |
// | Purpose  : Dual-port word memory with fixed per-port wait-state latency.  |
// |            Port A is read-only (instruction side), port B reads or       |
// |            writes with byte enables (data side). Each port runs its own  |
// |            IDLE -> WAIT -> RESP sequencer and answers with a one-cycle   |
// |            resp pulse LATENCY cycles after the accepting edge.           |
// | Ports    : clk, rst_n (async, active-low)                                |
// |            A: i_read_a, i_address_a -> o_resp_a, o_rdata_a              |
// |            B: i_read_b, i_write_b, i_wmask_b, i_address_b, i_wdata_b    |
// |               -> o_resp_b, o_rdata_b                                    |
// |            o_err_a, o_err_b only when DPMEM_RANGE_CHECK_EN is defined    |
// | Options  : DPMEM_RANGE_CHECK_EN - flag out-of-range byte addresses with  |
// |            err instead of wrapping them onto the storage.                |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module dp_wait_memory #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WORDS = 4096,
  parameter int LATENCY_A   = 2,
  parameter int LATENCY_B   = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_read_a,
  input  logic [31:0]             i_address_a,
  output logic                    o_resp_a,
  output logic [DATA_WIDTH-1:0]   o_rdata_a,
  input  logic                    i_read_b,
  input  logic                    i_write_b,
  input  logic [DATA_WIDTH/8-1:0] i_wmask_b,
  input  logic [31:0]             i_address_b,
  input  logic [DATA_WIDTH-1:0]   i_wdata_b,
  output logic                    o_resp_b,
  output logic [DATA_WIDTH-1:0]   o_rdata_b
`ifdef DPMEM_RANGE_CHECK_EN
  ,
  output logic                    o_err_a,
  output logic                    o_err_b
`endif
);

  localparam int c_BYTES = DATA_WIDTH / 8;
  localparam int c_OFS   = $clog2(c_BYTES);
  localparam int c_AW    = $clog2(DEPTH_WORDS);
  localparam int c_CW_A  = (LATENCY_A > 1) ? $clog2(LATENCY_A) : 1;
  localparam int c_CW_B  = (LATENCY_B > 1) ? $clog2(LATENCY_B) : 1;
  localparam logic [c_CW_A-1:0] c_LOAD_A = c_CW_A'(LATENCY_A - 1);
  localparam logic [c_CW_B-1:0] c_LOAD_B = c_CW_B'(LATENCY_B - 1);
  localparam bit c_DIRECT_A = (LATENCY_A == 1);
  localparam bit c_DIRECT_B = (LATENCY_B == 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH_WORDS];

  // ---------------- port A state ----------------
  state_t            r_st_a;
  logic [c_CW_A-1:0] r_cnt_a;
  logic [c_AW-1:0]   r_idx_a;
  logic              r_oor_a;
  logic              r_resp_a;
  logic [DATA_WIDTH-1:0] r_rdata_a;

  // ---------------- port B state ----------------
  state_t            r_st_b;
  logic [c_CW_B-1:0] r_cnt_b;
  logic [c_AW-1:0]   r_idx_b;
  logic              r_oor_b;
  logic              r_wr_b;
  logic [c_BYTES-1:0]    r_wmask_b;
  logic [DATA_WIDTH-1:0] r_wdata_b;
  logic              r_resp_b;
  logic [DATA_WIDTH-1:0] r_rdata_b;

  logic [c_AW-1:0] w_idx_a_in, w_idx_b_in;
  logic            w_oor_a_in, w_oor_b_in;
  logic            w_acc_a, w_acc_b;
  logic            w_enter_a, w_enter_b;
  logic [c_AW-1:0] w_samp_idx_a, w_samp_idx_b;
  logic            w_samp_oor_a, w_samp_oor_b;
  logic            w_samp_wr_b;
  logic [c_BYTES-1:0]    w_samp_mask_b;
  logic [DATA_WIDTH-1:0] w_samp_wdata_b;
  logic            w_commit_b;
  logic            w_unused_addr;

  // Byte-offset bits and upper address bits do not select a word.
  assign w_unused_addr = ^{i_address_a, i_address_b};

  assign w_idx_a_in = i_address_a[c_OFS +: c_AW];
  assign w_idx_b_in = i_address_b[c_OFS +: c_AW];

`ifdef DPMEM_RANGE_CHECK_EN
  localparam logic [32:0] c_LIMIT = 33'(DEPTH_WORDS) * 33'(c_BYTES);
  assign w_oor_a_in = ({1'b0, i_address_a} >= c_LIMIT);
  assign w_oor_b_in = ({1'b0, i_address_b} >= c_LIMIT);
  // r_oor_* always describes the transaction currently in RESP.
  assign o_err_a = r_resp_a & r_oor_a;
  assign o_err_b = r_resp_b & r_oor_b;
`else
  assign w_oor_a_in = 1'b0;
  assign w_oor_b_in = 1'b0;
`endif

  // A request is taken in IDLE or on the edge that ends RESP. Gating with
  // rst_n keeps the accept (and any single-cycle write) out of reset.
  assign w_acc_a = rst_n & i_read_a & (r_st_a != S_WAIT);
  assign w_acc_b = rst_n & (i_read_b | i_write_b) & (r_st_b != S_WAIT);

  // RESP is entered from an expiring WAIT, or straight from the accept edge
  // when the latency is a single cycle.
  assign w_enter_a = ((r_st_a == S_WAIT) && (r_cnt_a == '0)) || (w_acc_a && c_DIRECT_A);
  assign w_enter_b = ((r_st_b == S_WAIT) && (r_cnt_b == '0)) || (w_acc_b && c_DIRECT_B);

  // While waiting, use the captured request; otherwise the live inputs are
  // the request being accepted on this very edge.
  assign w_samp_idx_a   = (r_st_a == S_WAIT) ? r_idx_a   : w_idx_a_in;
  assign w_samp_oor_a   = (r_st_a == S_WAIT) ? r_oor_a   : w_oor_a_in;
  assign w_samp_idx_b   = (r_st_b == S_WAIT) ? r_idx_b   : w_idx_b_in;
  assign w_samp_oor_b   = (r_st_b == S_WAIT) ? r_oor_b   : w_oor_b_in;
  assign w_samp_wr_b    = (r_st_b == S_WAIT) ? r_wr_b    : i_write_b;
  assign w_samp_mask_b  = (r_st_b == S_WAIT) ? r_wmask_b : i_wmask_b;
  assign w_samp_wdata_b = (r_st_b == S_WAIT) ? r_wdata_b : i_wdata_b;

  assign w_commit_b = w_enter_b & w_samp_wr_b & ~w_samp_oor_b;

  // ---------------- port A sequencer ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_st_a    <= S_IDLE;
      r_cnt_a   <= '0;
      r_idx_a   <= '0;
      r_oor_a   <= 1'b0;
      r_resp_a  <= 1'b0;
      r_rdata_a <= '0;
    end else begin
      r_resp_a  <= w_enter_a;
      // Nonblocking read: a port B write on the same edge is not yet visible.
      r_rdata_a <= (w_enter_a && !w_samp_oor_a) ? r_mem[w_samp_idx_a] : '0;
      case (r_st_a)
        S_WAIT: begin
          if (r_cnt_a == '0) r_st_a <= S_RESP;
          else               r_cnt_a <= r_cnt_a - 1'b1;
        end
        default: begin
          if (w_acc_a) begin
            r_idx_a <= w_idx_a_in;
            r_oor_a <= w_oor_a_in;
            r_cnt_a <= c_LOAD_A;
            r_st_a  <= c_DIRECT_A ? S_RESP : S_WAIT;
          end else begin
            r_st_a  <= S_IDLE;
          end
        end
      endcase
    end
  end

  // ---------------- port B sequencer ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_st_b    <= S_IDLE;
      r_cnt_b   <= '0;
      r_idx_b   <= '0;
      r_oor_b   <= 1'b0;
      r_wr_b    <= 1'b0;
      r_wmask_b <= '0;
      r_wdata_b <= '0;
      r_resp_b  <= 1'b0;
      r_rdata_b <= '0;
    end else begin
      r_resp_b  <= w_enter_b;
      // Writes (including read+write collisions) return zero data.
      r_rdata_b <= (w_enter_b && !w_samp_wr_b && !w_samp_oor_b) ? r_mem[w_samp_idx_b] : '0;
      case (r_st_b)
        S_WAIT: begin
          if (r_cnt_b == '0) r_st_b <= S_RESP;
          else               r_cnt_b <= r_cnt_b - 1'b1;
        end
        default: begin
          if (w_acc_b) begin
            r_idx_b   <= w_idx_b_in;
            r_oor_b   <= w_oor_b_in;
            r_wr_b    <= i_write_b;
            r_wmask_b <= i_wmask_b;
            r_wdata_b <= i_wdata_b;
            r_cnt_b   <= c_LOAD_B;
            r_st_b    <= c_DIRECT_B ? S_RESP : S_WAIT;
          end else begin
            r_st_b    <= S_IDLE;
          end
        end
      endcase
    end
  end

  // Storage is never reset; a write lands only on the edge entering RESP,
  // so a reset during WAIT discards it.
  always_ff @(posedge clk) begin
    if (w_commit_b) begin
      for (int i = 0; i < c_BYTES; i++) begin
        if (w_samp_mask_b[i]) r_mem[w_samp_idx_b][8*i +: 8] <= w_samp_wdata_b[8*i +: 8];
      end
    end
  end

  assign o_resp_a  = r_resp_a;
  assign o_rdata_a = r_rdata_a;
  assign o_resp_b  = r_resp_b;
  assign o_rdata_b = r_rdata_b;

endmodule
`default_nettype wire
